logic16_arbiter: RTL and testbench



---
 rtl/logic16_pkg.sv | 19 +
 rtl/logic16_unit.sv | 42 ++++
 rtl/logic16_arbiter.sv | 149 ++++++++++++++
 tb/tb_logic16_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic16_pkg.sv
// ---------------------------------------------------------------------------
// logic16_pkg
//   Shared definitions for the 16-bit logic-unit arbiter: opcode encodings
//   and the sequencer state type.
// ---------------------------------------------------------------------------
package logic16_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic16_unit.sv
// ---------------------------------------------------------------------------
// logic16_unit
//   Combinational op-select over the bitwise AND/OR/XOR/NOT gate blocks.
//   Ports:
//     op  in  2      opcode (OP_AND/OP_OR/OP_XOR/OP_NOT)
//     a   in  WIDTH  operand A
//     b   in  WIDTH  operand B (ignored for NOT)
//     y   out WIDTH  result
// ---------------------------------------------------------------------------
module logic16_unit
    import logic16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] or_y;
    logic [WIDTH-1:0] xor_y;
    logic [WIDTH-1:0] not_y;

    assign and_y = a & b;
    assign or_y  = a | b;
    assign xor_y = a ^ b;
    assign not_y = ~a;

    always_comb begin
        y = and_y;
        case (op)
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            OP_NOT:  y = not_y;
            default: y = and_y;
        endcase
    end

endmodule

// File: rtl/logic16_arbiter.sv
// ---------------------------------------------------------------------------
// logic16_arbiter
//   Round-robin arbiter + sequencer sharing one 16-bit logic unit among
//   N_REQ requesters. One operation at a time: IDLE (grant) -> EXEC
//   (compute, register result) -> RESP (hold until consumed).
//   Ports:
//     clk        in   1            clock, rising edge
//     reset      in   1            async active-high reset
//     req_valid  in   N_REQ        per-requester request valid
//     req_ready  out  N_REQ        one-hot accept (IDLE only)
//     req_op     in   2*N_REQ      opcode, requester i at [2i+1:2i]
//     req_a      in   WIDTH*N_REQ  operand A, requester i at [16i+15:16i]
//     req_b      in   WIDTH*N_REQ  operand B, same packing
//     rsp_valid  out  1            result valid
//     rsp_ready  in   1            consumer accepts result
//     rsp_data   out  WIDTH        result
//     rsp_id     out  ID_W         owning requester index
//     busy       out  1            state != IDLE
// ---------------------------------------------------------------------------
module logic16_arbiter
    import logic16_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    // One extra bit so rr_ptr + k never overflows before the wrap correction.
    localparam int CW = ID_W + 1;

    state_e                        state_q;
    logic [ID_W-1:0]               rr_ptr_q;
    logic [ID_W-1:0]               rr_ptr_d;
    logic [1:0]                    op_q;
    logic [WIDTH-1:0]              a_q;
    logic [WIDTH-1:0]              b_q;
    logic [ID_W-1:0]               gid_q;
    logic                          rsp_valid_q;
    logic [WIDTH-1:0]              rsp_data_q;
    logic [ID_W-1:0]               rsp_id_q;

    logic [N_REQ-1:0][1:0]         op_arr;
    logic [N_REQ-1:0][WIDTH-1:0]   a_arr;
    logic [N_REQ-1:0][WIDTH-1:0]   b_arr;

    logic [N_REQ-1:0]              gnt;
    logic [ID_W-1:0]               gnt_idx;
    logic                          found;
    logic [CW-1:0]                 sum;
    logic [ID_W-1:0]               idx;
    logic [WIDTH-1:0]              unit_y;

    assign op_arr = req_op;
    assign a_arr  = req_a;
    assign b_arr  = req_b;

    // Rotating priority scan: first valid requester at or after rr_ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + CW'(k);
            if (sum >= CW'(N_REQ)) begin
                sum = sum - CW'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    assign rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // Grant depends only on state and req_valid, never on rsp_ready.
    assign req_ready = (state_q == S_IDLE) ? gnt : '0;

    logic16_unit #(.WIDTH(WIDTH)) u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (unit_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gid_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // In IDLE req_ready equals gnt, so found is the handshake.
                    if (found) begin
                        op_q     <= op_arr[gnt_idx];
                        a_q      <= a_arr[gnt_idx];
                        b_q      <= b_arr[gnt_idx];
                        gid_q    <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= unit_y;
                    rsp_id_q    <= gid_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic16_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic16_arbiter
//   Scenario tasks for the logic16_arbiter. Expected results are pushed to a
//   scoreboard queue at each request handshake and popped at each response
//   handshake.
// ---------------------------------------------------------------------------
module tb_logic16_arbiter;
    import logic16_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             busy;

    always #5 clk = ~clk;

    logic16_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [IW+W-1:0] sb[$];
    int              g_id[$];
    int              g_cyc[$];
    logic            rsp_fire;
    logic            rsp_unexp;
    logic [IW+W-1:0] rsp_got;
    logic [IW+W-1:0] rsp_exp;

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_op[2*i +: 2] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    // Samples both handshakes just before the edge, updates the scoreboard,
    // then advances to 1 time unit past the next rising edge.
    task automatic tick();
        #1;
        rsp_fire  = rsp_valid & rsp_ready;
        rsp_unexp = 1'b0;
        rsp_exp   = '0;
        rsp_got   = {rsp_id, rsp_data};
        if (rsp_fire) begin
            if (sb.size() > 0) rsp_exp = sb.pop_front();
            else               rsp_unexp = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back({IW'(i), model(req_op[2*i +: 2], req_a[W*i +: W], req_b[W*i +: W])});
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        g_id.delete();
        g_cyc.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h id=%0d busy=%b want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_id, busy);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || req_ready !== '0) begin
                n_err++;
                $display("FAIL idle_stays_idle: got busy=%b rdy=%b want 0/0000", busy, req_ready);
            end
        end
    endtask

    task automatic test_single_and();
        req_valid = 4'b0001;
        set_req(0, OP_AND, 16'hF0F0, 16'hFF00);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL and_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL and_exec: got vld=%b busy=%b want 0/1", rsp_valid, busy);
        end
        tick();
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL and_latency: got rsp_valid=%b want 1", rsp_valid);
        end
        tick();
        n_cmp++;
        if (!rsp_fire || rsp_got !== {2'd0, 16'hF000}) begin
            n_err++;
            $display("FAIL and_result: got fire=%b id/data=%h want 1 0f000", rsp_fire, rsp_got);
        end
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL and_release: got vld=%b busy=%b want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, OP_OR, 16'h00FF, 16'h0F00);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (rsp_fire) begin
                n_cmp++;
                if (rsp_unexp || rsp_got[W-1:0] !== 16'h0FFF || rsp_got !== rsp_exp) begin
                    n_err++;
                    $display("FAIL rr_result: got %h want %h (unexpected=%b)", rsp_got, rsp_exp, rsp_unexp);
                end
            end
        end
        req_valid = '0;
        n_cmp++;
        if (g_id.size() != 5 || sb.size() != 0) begin
            n_err++;
            $display("FAIL rr_count: got grants=%0d pending=%0d want 5/0", g_id.size(), sb.size());
        end
        for (int j = 0; j < g_id.size() && j < 5; j++) begin
            n_cmp++;
            if (g_id[j] != j % N) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", j, g_id[j], j % N);
            end
        end
        for (int j = 1; j < g_cyc.size(); j++) begin
            n_cmp++;
            if (g_cyc[j] - g_cyc[j-1] != 3) begin
                n_err++;
                $display("FAIL rr_spacing[%0d]: got %0d want 3", j, g_cyc[j] - g_cyc[j-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        g_id.delete();
        set_req(2, OP_XOR, 16'hAAAA, 16'hFFFF);
        set_req(0, OP_AND, 16'h1234, 16'h00FF);
        req_valid = 4'b0101;
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_grant2: got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h5555 || rsp_id !== 2'd2 || req_ready !== '0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got vld=%b data=%h id=%0d rdy=%b want 1/5555/2/0000",
                         k, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            tick();
        end
        n_cmp++;
        if (g_id.size() != 1) begin
            n_err++;
            $display("FAIL bp_no_early_grant: got grants=%0d want 1", g_id.size());
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if (!rsp_fire || rsp_unexp || rsp_got !== rsp_exp || rsp_got !== {2'd2, 16'h5555}) begin
            n_err++;
            $display("FAIL bp_result: got fire=%b %h want 2_5555", rsp_fire, rsp_got);
        end
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_next_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++;
        if (!rsp_fire || rsp_unexp || rsp_got !== rsp_exp) begin
            n_err++;
            $display("FAIL bp_second: got fire=%b %h want %h", rsp_fire, rsp_got, rsp_exp);
        end
    endtask

    task automatic test_wrap_skip();
        // Grant requester 2 alone so the pointer lands on 3.
        set_req(2, OP_AND, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++;
        if (!rsp_fire || rsp_unexp || rsp_got !== {2'd2, 16'hFFFF}) begin
            n_err++;
            $display("FAIL wrap_setup: got fire=%b %h want 2_ffff", rsp_fire, rsp_got);
        end
        set_req(1, OP_NOT, 16'h1234, 16'($urandom));
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL wrap_grant1: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++;
        if (!rsp_fire || rsp_unexp || rsp_got !== rsp_exp || rsp_got !== {2'd1, 16'hEDCB}) begin
            n_err++;
            $display("FAIL wrap_not: got fire=%b %h want 1_edcb", rsp_fire, rsp_got);
        end
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL wrap_ptr2: got %b want 0100", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midop();
        int n_fire;
        set_req(3, OP_XOR, 16'h1111, 16'h2222);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        // Now in EXEC with requester 3 in flight.
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL midop_reset: got vld=%b busy=%b rdy=%b want 0/0/0000", rsp_valid, busy, req_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        n_fire = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_fire) n_fire++;
        end
        n_cmp++;
        if (n_fire != 0) begin
            n_err++;
            $display("FAIL midop_no_rsp: got %0d responses (last %h) want 0", n_fire, rsp_got);
        end
        for (int i = 0; i < N; i++) set_req(i, OP_OR, 16'h0F0F, 16'(i));
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL midop_grant0: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++;
        if (!rsp_fire || rsp_unexp || rsp_got !== rsp_exp || rsp_got !== {2'd0, 16'h0F0F}) begin
            n_err++;
            $display("FAIL midop_after: got fire=%b %h want 0_0f0f", rsp_fire, rsp_got);
        end
    endtask

    initial begin
        test_reset();
        test_single_and();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
